// File: rtl/execute_stage.sv
// Execute stage: 16x32 register file, ALU, multi-cycle unsigned multiply with decode stall.
// Optional EXEC_FWD_EN enables result forwarding and writeback write-through on operand reads.
module execute_stage #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  opcode_in_e,
    input  logic [3:0]  dest_in_e,
    input  logic [3:0]  s1_in_e,
    input  logic [3:0]  s2_in_e,
    input  logic [31:0] ime_data_in_e,
    input  logic        wb_we_in_e,
    input  logic [3:0]  wb_dest_in_e,
    input  logic [31:0] wb_data_in_e,
    output logic [4:0]  opcode_out_e,
    output logic [3:0]  dest_out_e,
    output logic [31:0] result_out_e,
    output logic        wr_en_out_e,
    output logic        illegal_out_e,
    output logic        stall_out_e
);

    // state | meaning
    // IDLE  | one instruction accepted per edge
    // MUL   | multiply in flight, inputs ignored, bubbles on outputs
    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_MOVI = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_SLTU = 5'd11;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [3:0]  mul_dest;
    logic [31:0] mul_prod;
    logic [31:0] regs [16];
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        alu_we;
    logic        alu_ill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wb_we_in_e && wb_dest_in_e != 4'd0) begin
            regs[wb_dest_in_e] <= wb_data_in_e;
        end
    end

    // Later assignments take priority: r0 > forward > write-through > register file
    always_comb begin
        op_a = regs[s1_in_e];
        op_b = regs[s2_in_e];
`ifdef EXEC_FWD_EN
        if (wb_we_in_e && wb_dest_in_e == s1_in_e) op_a = wb_data_in_e;
        if (wb_we_in_e && wb_dest_in_e == s2_in_e) op_b = wb_data_in_e;
        if (wr_en_out_e && dest_out_e == s1_in_e) op_a = result_out_e;
        if (wr_en_out_e && dest_out_e == s2_in_e) op_b = result_out_e;
`endif
        if (s1_in_e == 4'd0) op_a = '0;
        if (s2_in_e == 4'd0) op_b = '0;
    end

    always_comb begin
        alu_res = '0;
        alu_we  = 1'b1;
        alu_ill = 1'b0;
        case (opcode_in_e)
            OP_NOP:  alu_we  = 1'b0;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << op_b[4:0];
            OP_SHR:  alu_res = op_a >> op_b[4:0];
            OP_ADDI: alu_res = op_a + ime_data_in_e;
            OP_MOVI: alu_res = ime_data_in_e;
            OP_MUL:  alu_we  = 1'b0;
            OP_SLTU: alu_res = {31'd0, op_a < op_b};
            default: begin
                alu_we  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    assign mul_prod = mul_a * mul_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            mul_dest      <= '0;
            opcode_out_e  <= '0;
            dest_out_e    <= '0;
            result_out_e  <= '0;
            wr_en_out_e   <= 1'b0;
            illegal_out_e <= 1'b0;
            stall_out_e   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (opcode_in_e == OP_MUL) begin
                        state         <= MUL;
                        cnt           <= CNT_LOAD;
                        mul_a         <= op_a;
                        mul_b         <= op_b;
                        mul_dest      <= dest_in_e;
                        stall_out_e   <= 1'b1;
                        opcode_out_e  <= '0;
                        dest_out_e    <= '0;
                        result_out_e  <= '0;
                        wr_en_out_e   <= 1'b0;
                        illegal_out_e <= 1'b0;
                    end else begin
                        opcode_out_e  <= opcode_in_e;
                        dest_out_e    <= dest_in_e;
                        result_out_e  <= alu_res;
                        wr_en_out_e   <= alu_we;
                        illegal_out_e <= alu_ill;
                    end
                end
                MUL: begin
                    if (cnt == 4'd1) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        stall_out_e  <= 1'b0;
                        opcode_out_e <= OP_MUL;
                        dest_out_e   <= mul_dest;
                        result_out_e <= mul_prod;
                        wr_en_out_e  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios, random instruction stream, reset mid-multiply.
module tb_execute_stage;
    localparam int M = 4;

    typedef struct {
        logic        stall;
        logic [4:0]  op;
        logic [3:0]  dest;
        logic [31:0] res;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  opcode_in_e = '0;
    logic [3:0]  dest_in_e = '0;
    logic [3:0]  s1_in_e = '0;
    logic [3:0]  s2_in_e = '0;
    logic [31:0] ime_data_in_e = '0;
    logic        wb_we_in_e = 1'b0;
    logic [3:0]  wb_dest_in_e = '0;
    logic [31:0] wb_data_in_e = '0;
    logic [4:0]  opcode_out_e;
    logic [3:0]  dest_out_e;
    logic [31:0] result_out_e;
    logic        wr_en_out_e;
    logic        illegal_out_e;
    logic        stall_out_e;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    exp_t        q[$];
    exp_t        prev;
    logic [31:0] mreg [16];

    execute_stage #(.MUL_CYCLES(M)) dut (
        .clk(clk), .reset_n(reset_n),
        .opcode_in_e(opcode_in_e), .dest_in_e(dest_in_e),
        .s1_in_e(s1_in_e), .s2_in_e(s2_in_e), .ime_data_in_e(ime_data_in_e),
        .wb_we_in_e(wb_we_in_e), .wb_dest_in_e(wb_dest_in_e), .wb_data_in_e(wb_data_in_e),
        .opcode_out_e(opcode_out_e), .dest_out_e(dest_out_e), .result_out_e(result_out_e),
        .wr_en_out_e(wr_en_out_e), .illegal_out_e(illegal_out_e), .stall_out_e(stall_out_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", 32'(stall_out_e), 32'(e.stall));
            chk("opcode", 32'(opcode_out_e), 32'(e.op));
            chk("wr_en", 32'(wr_en_out_e), 32'(e.we));
            chk("illegal", 32'(illegal_out_e), 32'(e.ill));
            if (e.we) begin
                chk("dest", 32'(dest_out_e), 32'(e.dest));
                chk("result", result_out_e, e.res);
            end else if (!e.stall && e.op == 5'd0) begin
                chk("nop_result", result_out_e, 32'd0);
            end
        end
    end

    function automatic logic [31:0] operand(input logic [3:0] idx);
        if (idx == 4'd0) return 32'd0;
`ifdef EXEC_FWD_EN
        if (prev.we && prev.dest == idx) return prev.res;
        if (wb_we_in_e && wb_dest_in_e == idx) return wb_data_in_e;
`endif
        return mreg[idx];
    endfunction

    function automatic exp_t predict(input logic [4:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [31:0] imm);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        a = operand(s1);
        b = operand(s2);
        p = 64'(a) * 64'(b);
        e.stall = 1'b0;
        e.op    = op;
        e.dest  = d;
        e.we    = (op >= 5'd1 && op <= 5'd11);
        e.ill   = (op >= 5'd12);
        case (op)
            5'd1:    e.res = a + b;
            5'd2:    e.res = a - b;
            5'd3:    e.res = a & b;
            5'd4:    e.res = a | b;
            5'd5:    e.res = a ^ b;
            5'd6:    e.res = a << b[4:0];
            5'd7:    e.res = a >> b[4:0];
            5'd8:    e.res = a + imm;
            5'd9:    e.res = imm;
            5'd10:   e.res = p[31:0];
            5'd11:   e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        return e;
    endfunction

    task automatic commit_wb();
        if (wb_we_in_e && wb_dest_in_e != 4'd0) mreg[wb_dest_in_e] = wb_data_in_e;
    endtask

    task automatic rand_wb();
        wb_we_in_e   = 1'($urandom_range(0, 1));
        wb_dest_in_e = 4'($urandom_range(0, 15));
        wb_data_in_e = $urandom();
    endtask

    // Called #1 after an edge; returns #1 after the edge(s) that consume the instruction.
    task automatic issue(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [31:0] imm, input logic wwe,
                         input logic [3:0] wd, input logic [31:0] wdat);
        exp_t e;
        exp_t bub;
        opcode_in_e = op; dest_in_e = d; s1_in_e = s1; s2_in_e = s2; ime_data_in_e = imm;
        wb_we_in_e = wwe; wb_dest_in_e = wd; wb_data_in_e = wdat;
        e = predict(op, d, s1, s2, imm);
        @(posedge clk);
        commit_wb();
        if (op == 5'd10) begin
            bub = '{stall: 1'b1, op: 5'd0, dest: 4'd0, res: 32'd0, we: 1'b0, ill: 1'b0};
            for (int i = 0; i < M - 1; i++) q.push_back(bub);
        end
        q.push_back(e);
        prev = e;
        #1;
        if (op == 5'd10) begin
            // Inputs during the stall must be ignored, so drive junk rather than holding
            for (int i = 0; i < M - 1; i++) begin
                opcode_in_e = 5'($urandom_range(0, 31));
                dest_in_e = 4'($urandom()); s1_in_e = 4'($urandom()); s2_in_e = 4'($urandom());
                ime_data_in_e = $urandom();
                rand_wb();
                @(posedge clk);
                commit_wb();
                #1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
        prev = '{stall: 1'b0, op: 5'd0, dest: 4'd0, res: 32'd0, we: 1'b0, ill: 1'b0};
        q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_opcode"}, 32'(opcode_out_e), 32'd0);
        chk({tag, "_dest"}, 32'(dest_out_e), 32'd0);
        chk({tag, "_result"}, result_out_e, 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en_out_e), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_out_e), 32'd0);
        chk({tag, "_stall"}, 32'(stall_out_e), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        model_reset();
        #2 reset_n = 1'b0;
        #1 chk_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset_hold");
        reset_n = 1'b1;
        mon_en = 1'b1;

        // Directed scenarios
        issue(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1, 32'd5);
        issue(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2, 32'd7);
        issue(5'd1, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd1, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd8, 4'd4, 4'd3, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0);
        issue(5'd10, 4'd5, 4'd1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd1, 4'd8, 4'd5, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd31, 4'd9, 4'd1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd1, 4'd9, 4'd1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd0, 32'hDEADBEEF);
        issue(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1, 32'd1);
        issue(5'd2, 4'd6, 4'd0, 4'd1, 32'd0, 1'b0, 4'd0, 32'd0);

        // Random stream; small register indices make hazards frequent
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 5) op = 5'($urandom_range(12, 31));
            else op = 5'($urandom_range(0, 11));
            issue(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom());
        end

        // Reset two edges into a multiply
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'd0);
        opcode_in_e = 5'd10; dest_in_e = 4'd1; s1_in_e = 4'd3; s2_in_e = 4'd4;
        wb_we_in_e = 1'b0;
        @(posedge clk);
        #1 opcode_in_e = 5'd0;
        @(posedge clk);
        #1 chk("mid_mul_stall", 32'(stall_out_e), 32'd1);
        reset_n = 1'b0;
        #1 chk_all_zero("reset_mid_mul");
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        for (int i = 0; i < M + 1; i++) issue(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd1, 4'd7, 4'd1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        #1 chk("final_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Third stage of the four-stage pipelined controller, directly downstream of the decode stage. Consumes the registered opcode, destination, source-register indices and immediate from decode, owns the 16 x 32 register file, performs the ALU operation and registers result, destination and write-enable for the writeback stage. Multiply is multi-cycle and stalls the decode stage through a one-bit stall handshake.

## Interface
Parameters:
- MUL_CYCLES, 4: total clock edges from accepting MUL to registering its result (legal range 2..15).

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode_in_e  in  5  opcode from decode.
- dest_in_e  in  4  destination register index.
- s1_in_e  in  4  source-1 register index.
- s2_in_e  in  4  source-2 register index.
- ime_data_in_e  in  32  immediate.
- wb_we_in_e  in  1  writeback-stage register-file write enable.
- wb_dest_in_e  in  4  writeback write index.
- wb_data_in_e  in  32  writeback write data.
- opcode_out_e  out  5  registered opcode; 0 during bubbles.
- dest_out_e  out  4  registered destination.
- result_out_e  out  32  registered ALU result.
- wr_en_out_e  out  1  result must be written by writeback.
- illegal_out_e  out  1  one-cycle pulse for an undefined opcode.
- stall_out_e  out  1  registered; decode must hold its outputs while high.

## Operation
- Opcodes: 0 NOP; 1 ADD s1+s2; 2 SUB s1-s2; 3 AND; 4 OR; 5 XOR; 6 SHL s1<<s2[4:0]; 7 SHR logical s1>>s2[4:0]; 8 ADDI s1+imm; 9 MOVI imm; 10 MUL low 32 bits of s1*s2 (unsigned); 11 SLTU (s1<s2 unsigned)?1:0; 12-31 illegal.
- All arithmetic is modulo 2^32; carries and the upper product half are discarded.
- Operand read order, highest priority first: index 0 reads 0; forward from result_out_e when wr_en_out_e=1 and dest_out_e matches; write-through of wb_data_in_e when wb_we_in_e=1 and wb_dest_in_e matches; register-file content.
- Register-file writes: on wb_we_in_e at the clock edge. Writes to r0 are ignored.
- FSM states:
  - IDLE: the input is accepted every edge.
  - MUL: entered on accepting opcode 10. Operands are latched, a counter is loaded with MUL_CYCLES-1, and it decrements each edge. When the counter reaches 1, the next edge registers the result and returns to IDLE.
- Illegal opcode: illegal_out_e=1 for one cycle; wr_en_out_e=0; opcode_out_e carries the illegal code; the register file is unchanged.
- NOP: wr_en_out_e=0; result_out_e=0.

## Timing
- Reset: every output is 0; all 16 registers are 0; FSM is IDLE; counter is 0. Reset takes effect immediately, independent of clk.
- Non-MUL latency: an instruction present before edge N appears on the outputs after edge N.
- MUL latency:
  - Accepted at edge N; stall_out_e is high after edges N..N+MUL_CYCLES-2.
  - The result, wr_en_out_e=1 and dest are registered at edge N+MUL_CYCLES-1, and stall falls at the same edge.
  - The next instruction is accepted at edge N+MUL_CYCLES.
- While stall_out_e=1: inputs are ignored; outputs present a bubble (opcode 0, wr_en 0, illegal 0).
- The writeback port stays active during the stall.
- Reset asserted mid-MUL aborts the multiply: no result is produced, and stall drops immediately.
- Forwarding covers a back-to-back dependency. A dependency two instructions back is covered by the wb write-through.

## Configuration
- EXEC_FWD_EN defined: the result_out_e forward path and the wb write-through are both present, as above.
- EXEC_FWD_EN undefined: operands come from the register file only (r0 still reads 0). Back-to-back and distance-2 hazards read stale values; avoiding them is the compiler's responsibility.

## Test plan
- Reset, then wb writes r1=5 and r2=7; ADD dest3 s1=1 s2=2 -> after the next edge result_out_e=12, dest_out_e=3, wr_en_out_e=1.
- ADD r3=r1+r2 followed immediately by ADDI r4=r3+1 (imm 1), with r3 not yet written back -> 13 with EXEC_FWD_EN; 1 without it.
- MUL r5=r1*r2 with MUL_CYCLES=4 -> stall_out_e high for exactly 3 cycles with bubble outputs. result_out_e=35 and wr_en_out_e=1 after the 4th edge. The held next instruction executes one edge later.
- Opcode 31 -> illegal_out_e pulses for 1 cycle, wr_en_out_e=0; a following ADD executes normally.
- wb write r0=0xDEADBEEF, then SUB dest6 s1=0 s2=1 (r1=1) -> result 0xFFFFFFFF (r0 still reads 0, wrap-around).
- Assert reset_n low two edges into a MUL -> all outputs and stall go to 0 immediately. After release, no MUL result appears and r1 reads 0.
